// File: rtl/spi_master_cfg.sv
// spi_master_cfg: configurable SPI master (CPOL/CPHA, slave select, MSB first).
// Ports: clk/rst, start+cfg in, miso; sclk/mosi/ss_n out, busy/done/rx_data status.
module spi_master_cfg #(
  parameter int DATA_W  = 8,
  parameter int SEL_W   = 2,
  parameter int CLK_DIV = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    cpol,
  input  logic                    cpha,
  input  logic [SEL_W-1:0]        ss_sel,
  input  logic [DATA_W-1:0]       tx_data,
  input  logic                    miso,
  output logic                    sclk,
  output logic                    mosi,
  output logic [(1<<SEL_W)-1:0]   ss_n,
  output logic                    busy,
  output logic                    done,
  output logic [DATA_W-1:0]       rx_data
);

  localparam int NUM_SS = 1 << SEL_W;
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EW = $clog2(2*DATA_W + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
  localparam logic [EW-1:0] EDGE_LAST = EW'(2*DATA_W - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEAD  = 3'd1;
  localparam logic [2:0] S_XFER  = 3'd2;
  localparam logic [2:0] S_TRAIL = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [EW-1:0]     ecnt_q, ecnt_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rsh_q, rsh_d;
  logic [DATA_W-1:0] rx_q, rx_d;

  logic tick;
  logic lead;
  logic samp;

  always_comb begin
    tick    = (cnt_q == CNT_MAX);
    // an even count of edges so far means the next edge is a leading one
    lead    = ~ecnt_q[0];
    samp    = lead ^ cpha_q;
    state_d = state_q;
    cnt_d   = tick ? '0 : cnt_q + CW'(1);
    ecnt_d  = ecnt_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    sel_d   = sel_q;
    tx_d    = tx_q;
    rsh_d   = rsh_q;
    rx_d    = rx_q;
    case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        sclk_d = cpol;
        mosi_d = 1'b0;
        if (start) begin
          state_d = S_LEAD;
          cpol_d  = cpol;
          cpha_d  = cpha;
          sel_d   = ss_sel;
          ecnt_d  = '0;
          rsh_d   = '0;
          // cpha=0 presents the MSB before the first edge
          if (cpha) begin
            tx_d = tx_data;
          end else begin
            mosi_d = tx_data[DATA_W-1];
            tx_d   = {tx_data[DATA_W-2:0], 1'b0};
          end
        end
      end
      S_LEAD: begin
        if (tick) state_d = S_XFER;
      end
      S_XFER: begin
        if (tick) begin
          sclk_d = ~sclk_q;
          ecnt_d = ecnt_q + EW'(1);
          if (samp) begin
            rsh_d = {rsh_q[DATA_W-2:0], miso};
          end else if (cpha_q || ecnt_q != EDGE_LAST) begin
            mosi_d = tx_q[DATA_W-1];
            tx_d   = {tx_q[DATA_W-2:0], 1'b0};
          end
          if (ecnt_q == EDGE_LAST) state_d = S_TRAIL;
        end
      end
      S_TRAIL: begin
        sclk_d = cpol_q;
        if (tick) begin
          state_d = S_DONE;
          rx_d    = rsh_q;
          mosi_d  = 1'b0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ecnt_q  <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      sel_q   <= '0;
      tx_q    <= '0;
      rsh_q   <= '0;
      rx_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ecnt_q  <= ecnt_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      sel_q   <= sel_d;
      tx_q    <= tx_d;
      rsh_q   <= rsh_d;
      rx_q    <= rx_d;
    end
  end

  assign busy    = (state_q == S_LEAD) || (state_q == S_XFER) ||
                   (state_q == S_TRAIL);
  assign done    = (state_q == S_DONE);
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign rx_data = rx_q;
  assign ss_n    = busy ? ~(NUM_SS'(1) << sel_q) : '1;

endmodule

// File: tb/tb_spi_master_cfg.sv
// tb_spi_master_cfg: vector table + scoreboard bench for spi_master_cfg.
// Covers modes 0-3, slave select, restart, reset abort, CLK_DIV=1 back-to-back.
module tb_spi_master_cfg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, cpol, cpha, miso;
  logic [1:0] ss_sel;
  logic [7:0] tx_data, rx_data;
  logic       sclk, mosi, busy, done;
  logic [3:0] ss_n;

  logic       b_start, b_sclk, b_mosi, b_busy, b_done;
  logic [7:0] b_tx, b_rx;
  logic [3:0] b_ss_n;

  spi_master_cfg #(.DATA_W(8), .SEL_W(2), .CLK_DIV(2)) dut (
    .clk(clk), .rst(rst), .start(start), .cpol(cpol), .cpha(cpha),
    .ss_sel(ss_sel), .tx_data(tx_data), .miso(miso), .sclk(sclk),
    .mosi(mosi), .ss_n(ss_n), .busy(busy), .done(done),
    .rx_data(rx_data)
  );

  spi_master_cfg #(.DATA_W(8), .SEL_W(2), .CLK_DIV(1)) dutb (
    .clk(clk), .rst(rst), .start(b_start), .cpol(1'b0), .cpha(1'b0),
    .ss_sel(2'd0), .tx_data(b_tx), .miso(b_mosi), .sclk(b_sclk),
    .mosi(b_mosi), .ss_n(b_ss_n), .busy(b_busy), .done(b_done),
    .rx_data(b_rx)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // slave model: 0 loopback, 1 constant one, 2 shifts m_pat out
  int         m_mode;
  logic [7:0] m_pat;
  logic       m_cpha;
  logic       prev_sclk;
  int         ecnt;
  int         seen, idx;

  always @(posedge clk) begin
    prev_sclk <= sclk;
    if (!busy) ecnt <= 0;
    else if (sclk != prev_sclk) ecnt <= ecnt + 1;
  end

  always_comb begin
    seen = ecnt + ((busy && sclk != prev_sclk) ? 1 : 0);
    idx  = m_cpha ? (seen + 1) / 2 - 1 : seen / 2;
    miso = 1'b0;
    if (m_mode == 0) miso = mosi;
    else if (m_mode == 1) miso = 1'b1;
    else if (idx >= 0 && idx < 8) miso = m_pat[7-idx];
  end

  typedef struct {
    logic       cpol;
    logic       cpha;
    logic [1:0] sel;
    logic [7:0] tx;
    int         mmode;
    logic [7:0] pat;
    int         restart_at;
    logic [7:0] exp_rx;
    logic [3:0] exp_ss;
  } vec_t;

  typedef struct {
    logic [7:0] rx;
    int         cyc;
  } exp_t;

  exp_t sbq[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v);
    int   nb, nss, ne, nd, nm;
    logic ps;
    logic [7:0] mo;
    exp_t e;
    nb = 0; nss = 0; ne = 0; nd = 0; nm = 0; mo = '0;
    @(negedge clk);
    cpol = v.cpol; cpha = v.cpha; ss_sel = v.sel; tx_data = v.tx;
    m_mode = v.mmode; m_pat = v.pat; m_cpha = v.cpha;
    @(negedge clk);
    chk("idle_sclk", {31'd0, sclk}, {31'd0, v.cpol});
    chk("idle_ss_n", {28'd0, ss_n}, 32'hf);
    start = 1'b1;
    sbq.push_back('{rx: v.exp_rx, cyc: cyc + 37});
    @(negedge clk);
    start = 1'b0;
    tx_data = ~v.tx; ss_sel = ~v.sel; cpol = ~v.cpol; cpha = ~v.cpha;
    ps = v.cpol;
    for (int c = 1; c <= 44; c++) begin
      start = (c == v.restart_at);
      if (c == v.restart_at) tx_data = 8'hff;
      if (busy) begin
        nb++;
        if (ss_n != v.exp_ss) nss++;
        if (sclk != ps) begin
          ne++;
          if (sclk != v.cpol && nm < 8) begin
            mo = {mo[6:0], mosi};
            nm++;
          end
        end
      end
      ps = sclk;
      if (done) begin
        nd++;
        chk("done_ss_n", {28'd0, ss_n}, 32'hf);
        chk("done_sclk", {31'd0, sclk}, {31'd0, v.cpol});
        if (sbq.size() == 0) begin
          chk("spurious_done", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("rx_data", {24'd0, rx_data}, {24'd0, e.rx});
          chk("done_cycle", cyc, e.cyc);
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("busy_cycles", nb, 36);
    chk("ss_n_busy_bad", nss, 0);
    chk("sclk_edges", ne, 16);
    chk("done_pulses", nd, 1);
    chk("rx_hold", {24'd0, rx_data}, {24'd0, v.exp_rx});
    if (v.cpha) chk("mosi_lead", {24'd0, mo}, {24'd0, v.tx});
  endtask

  vec_t tbl[6];
  int   nd;
  int   t0;
  logic found;

  initial begin
    tbl[0] = '{1'b0, 1'b0, 2'd2, 8'ha5, 0, 8'h00, 0, 8'ha5, 4'b1011};
    tbl[1] = '{1'b1, 1'b1, 2'd1, 8'h3c, 1, 8'h00, 0, 8'hff, 4'b1101};
    tbl[2] = '{1'b0, 1'b1, 2'd0, 8'h00, 2, 8'h5a, 0, 8'h5a, 4'b1110};
    tbl[3] = '{1'b1, 1'b0, 2'd3, 8'hc3, 2, 8'h96, 0, 8'h96, 4'b0111};
    tbl[4] = '{1'b0, 1'b0, 2'd1, 8'h33, 0, 8'h00, 10, 8'h33, 4'b1101};
    tbl[5] = '{1'b1, 1'b1, 2'd2, 8'h69, 0, 8'h00, 0, 8'h69, 4'b1011};

    rst = 1'b1; start = 1'b0; cpol = 1'b0; cpha = 1'b0;
    ss_sel = '0; tx_data = '0; b_start = 1'b0; b_tx = '0;
    m_mode = 0; m_pat = '0; m_cpha = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ss_n", {28'd0, ss_n}, 32'hf);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sclk", {31'd0, sclk}, 32'd0);
    chk("rst_mosi", {31'd0, mosi}, 32'd0);
    chk("rst_rx", {24'd0, rx_data}, 32'd0);
    rst = 1'b0;

    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("start_with_rst", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("start_with_rst2", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 6; i++) run(tbl[i]);

    // reset in the middle of a transfer
    @(negedge clk);
    cpol = 1'b1; cpha = 1'b0; ss_sel = 2'd1; tx_data = 8'h5a; m_mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    chk("abort_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ss_n", {28'd0, ss_n}, 32'hf);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_sclk", {31'd0, sclk}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_rx", {24'd0, rx_data}, 32'd0);
    nd = 0;
    for (int c = 0; c < 30; c++) begin
      if (done) nd++;
      @(negedge clk);
    end
    chk("abort_no_done", nd, 0);

    run(tbl[0]);

    // CLK_DIV=1 instance: timing and back-to-back start
    @(negedge clk);
    b_tx = 8'h81; b_start = 1'b1; t0 = cyc;
    @(negedge clk);
    b_start = 1'b0; b_tx = '0;
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      if (b_done) found = 1'b1;
      else @(negedge clk);
    end
    chk("b_done_seen", {31'd0, found}, 32'd1);
    chk("b_done_cycle", cyc - t0, 32'd19);
    chk("b_rx", {24'd0, b_rx}, 32'h81);
    b_start = 1'b1; b_tx = 8'h42;
    @(negedge clk);
    t0 = cyc;
    chk("b_idle_after_done", {31'd0, b_busy}, 32'd0);
    @(negedge clk);
    b_start = 1'b0; b_tx = '0;
    chk("b2b_busy", {31'd0, b_busy}, 32'd1);
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      if (b_done) found = 1'b1;
      else @(negedge clk);
    end
    chk("b2b_done_seen", {31'd0, found}, 32'd1);
    chk("b2b_done_cycle", cyc - t0, 32'd19);
    chk("b2b_rx", {24'd0, b_rx}, 32'h42);

    chk("sb_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master_cfg.md
SPI_MASTER_CFG -- requirements
Module: spi_master_cfg

Interface
REQ-001 Parameters SHALL be, one per line:
  DATA_W   8   bits per transfer, >=2
  SEL_W    2   slave-select index width; slave count NUM_SS = 2**SEL_W
  CLK_DIV  2   clk cycles per SCLK half-period, >=1
REQ-002 Ports SHALL be, one per line:
  clk      in   1        system clock, all logic on rising edge
  rst      in   1        synchronous, active-high reset
  start    in   1        request transfer; sampled only in IDLE
  cpol     in   1        SCLK idle level; latched at start accept
  cpha     in   1        0: sample leading edge, 1: sample trailing edge; latched at start accept
  ss_sel   in   SEL_W    target slave index; latched at start accept
  tx_data  in   DATA_W   word to send, MSB first; latched at start accept
  miso     in   1        serial data from slave
  sclk     out  1        SPI clock
  mosi     out  1        serial data to slave
  ss_n     out  NUM_SS   active-low slave selects, one-hot-low when active
  busy     out  1        transfer in progress
  done     out  1        one-cycle pulse at transfer end
  rx_data  out  DATA_W   last received word

Function
REQ-003 FSM SHALL have states IDLE, LEAD, XFER, TRAIL, DONE.
REQ-004 A half-period tick SHALL occur every CLK_DIV clk cycles, counter cleared on every state entry.
REQ-005 IDLE: start=1 at cycle 0 -> cycle 1 LEAD, busy=1, ss_n[ss_sel]=0 (others 1), sclk=latched cpol, shift register=tx_data.
REQ-006 IDLE: sclk SHALL track registered cpol; mosi=0; ss_n all ones; busy=0.
REQ-007 LEAD SHALL last one half-period; cpha=0 -> mosi=tx_data MSB from LEAD entry.
REQ-008 XFER SHALL produce exactly 2*DATA_W SCLK edges, one per tick, then enter TRAIL.
REQ-009 cpha=0: miso sampled on each leading (odd) edge; mosi advances on each trailing edge except the last.
REQ-010 cpha=1: mosi advances on each leading edge (first leading edge drives MSB); miso sampled on each trailing edge.
REQ-011 Received bits SHALL shift in MSB first; after DATA_W samples the register holds the full word.
REQ-012 TRAIL SHALL hold sclk=cpol, ss_n asserted, for one half-period.
REQ-013 DONE SHALL last one cycle: done=1, busy=0, ss_n all ones, rx_data updated; next state IDLE.
REQ-014 done SHALL pulse at cycle (2*DATA_W+2)*CLK_DIV+1 after start cycle; busy high cycles 1..(2*DATA_W+2)*CLK_DIV.
REQ-015 start outside IDLE (including DONE) SHALL be ignored; cpol/cpha/ss_sel/tx_data changes mid-transfer SHALL have no effect.
REQ-016 rx_data SHALL hold its value between done pulses.
REQ-017 Back-to-back: start asserted in the cycle after DONE SHALL be accepted normally.

Reset
REQ-018 rst=1 at any clock edge SHALL force next cycle: IDLE, sclk=0, mosi=0, ss_n all ones, busy=0, done=0, rx_data=0, counters/shift registers cleared.
REQ-019 rst mid-transfer SHALL abort with no done pulse; rx_data SHALL read 0.
REQ-020 start asserted with rst SHALL be ignored.

Verification (DATA_W=8, SEL_W=2, CLK_DIV=2 unless stated)
REQ-021 Mode 0, ss_sel=2, tx_data=0xA5, miso=mosi loopback -> ss_n=4'b1011 while busy, 16 sclk edges, done at cycle 37, rx_data=0xA5.
REQ-022 Mode 3 (cpol=1,cpha=1), tx_data=0x3C, miso=1 -> sclk idles high before/after, mosi on falling edges shows 0,0,1,1,1,1,0,0, rx_data=0xFF.
REQ-023 Mode 1, ss_sel=0, slave model drives 0x5A on leading edges -> rx_data=0x5A, ss_n=4'b1110 while busy.
REQ-024 start pulsed again at cycle 10 of a transfer with tx_data=0xFF -> ignored; first transfer result unchanged, single done pulse.
REQ-025 rst asserted at cycle 20 of a transfer -> next cycle ss_n=4'b1111, busy=0, sclk=0, no done, rx_data=0; fresh start then completes normally.
REQ-026 CLK_DIV=1, tx_data=0x81, loopback -> done at cycle 19, rx_data=0x81; back-to-back start next cycle accepted.
